// File: rtl/result_pkg.sv
// Shared types and default widths for the struct_design result sink.
package result_pkg;

  localparam int RES_W     = 18;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic [16:0] data_C;
    logic        is_eq;
  } result_t;

endpackage

// File: rtl/result_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO of result_t beats.
// Latency: a write at edge N is visible at the head at edge N; the head reads 0 when empty.
// Backpressure: writes are dropped while full; a same-cycle read does not free the slot.
module result_fifo
  import result_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    wr_vld,
  input  result_t wr_dat,
  input  logic    rd_rdy,
  output result_t rd_dat,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  result_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = wr_vld && !full;
  assign pop   = rd_rdy && !empty;

  // Storage is never reset: the head is masked to 0 whenever the FIFO is empty.
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_collector.sv
// Purpose: sink for struct_design results; buffers beats and keeps saturating statistics.
// Latency: accepted beat at the head on the accepting edge; statistics one cycle after accept.
// Backpressure: in_ready low while the FIFO is full, no pass-through on a same-cycle pop.
module result_collector
  import result_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_data_C,
  input  logic             in_is_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:0]      out_data_C,
  output logic             out_is_eq,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_sum,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] total_count,
  output logic             acc_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  result_t    wr_dat;
  result_t    rd_dat;
  logic       full;
  logic       empty;
  logic       accept;

  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] tot_base;
  logic [CNT_W-1:0] eq_base;

  assign wr_dat = '{data_C: in_data_C, is_eq: in_is_eq};

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (in_valid),
    .wr_dat (wr_dat),
    .rd_rdy (out_ready),
    .rd_dat (rd_dat),
    .full   (full),
    .empty  (empty)
  );

  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_data_C = rd_dat.data_C;
  assign out_is_eq  = rd_dat.is_eq;
  assign accept     = in_valid && in_ready;

  // A clear coinciding with an accept restarts the statistics from that beat alone.
  always_comb begin
    acc_base = clear ? '0 : acc_sum;
    tot_base = clear ? '0 : total_count;
    eq_base  = clear ? '0 : eq_count;
    sum_ext  = {1'b0, acc_base} + (ACC_W+1)'(in_data_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum     <= '0;
      eq_count    <= '0;
      total_count <= '0;
      acc_ovf     <= 1'b0;
    end else if (accept) begin
      acc_sum     <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      acc_ovf     <= (acc_ovf && !clear) || sum_ext[ACC_W];
      total_count <= (tot_base == CNT_MAX) ? tot_base : tot_base + CNT_ONE;
      if (in_is_eq && eq_base != CNT_MAX) eq_count <= eq_base + CNT_ONE;
      else                                eq_count <= eq_base;
    end else if (clear) begin
      acc_sum     <= '0;
      eq_count    <= '0;
      total_count <= '0;
      acc_ovf     <= 1'b0;
    end
  end

endmodule

// File: doc/result_collector.md
# result_collector

Receiving end of the adder/comparator result interface: accepts `{data_C, is_eq}` result beats from the `struct_design` datapath over a valid/ready handshake and buffers them in a small FIFO for a downstream consumer. It also maintains running statistics over all accepted beats: a saturating sum accumulator, an equal-result count and a total beat count. It sits directly behind `struct_design` and replaces bench-side `$monitor` scraping with a synthesizable sink.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `ACC_W`, 24: accumulator width; must be at least 17.
- `CNT_W`, 8: width of `eq_count` and `total_count`.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  result beat present.
- `in_ready`  out  1  collector can accept a beat.
- `in_data_C`  in  17  sum result.
- `in_is_eq`  in  1  equality flag.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes the head.
- `out_data_C`  out  17  head sum.
- `out_is_eq`  out  1  head equality flag.
- `clear`  in  1  synchronous statistics clear.
- `acc_sum`  out  ACC_W  saturating sum of accepted `data_C`.
- `eq_count`  out  CNT_W  accepted beats with `is_eq`=1, saturating.
- `total_count`  out  CNT_W  accepted beats, saturating.
- `acc_ovf`  out  1  sticky; set when `acc_sum` saturates.

## Operation
- Accept when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. There is no pass-through when full, even if a pop occurs in the same cycle.
- `out_valid = (count != 0)`. `out_data_C`/`out_is_eq` are driven from the head entry. When empty they read 0.
- FIFO occupancy states:
  - EMPTY (count 0), PARTIAL, FULL (count `DEPTH`).
  - Push only: count+1. Pop only: count−1. Push and pop together: count unchanged, both pointers advance.
- Read/write pointers are `log2(DEPTH)` bits and wrap from `DEPTH`−1 to 0.
- Input `in_data_C`/`in_is_eq` are ignored when not accepted. Output stays stable while `out_valid && !out_ready`.
- Statistics update on accept only (not on pop):
  - `acc_sum += zero-extended in_data_C`. If the true sum exceeds 2^ACC_W−1, `acc_sum` clamps to all-ones and `acc_ovf` is set.
  - `total_count` +1 and, if `in_is_eq`, `eq_count` +1. Each clamps at 2^CNT_W−1; counters do not set `acc_ovf`.
- `clear` zeroes `acc_sum`, `eq_count`, `total_count` and `acc_ovf` next cycle. It does not touch the FIFO.
  - `clear` together with an accept: the stats load that beat's contribution alone (`acc_sum=data_C`, `total_count=1`, `eq_count=is_eq`).

## Timing
- Reset (`rst_n`=0, asynchronous): FIFO empty, pointers 0, `in_ready`=1, `out_valid`=0, `out_data_C`=0, `out_is_eq`=0, all statistics 0, `acc_ovf`=0.
- Reset asserted mid-operation discards all buffered beats immediately.
- Latency: a beat accepted at edge N appears on the output at edge N (registered). `out_valid` is high in cycle N+1.
- Statistics reflect an accept one cycle after the accepting edge.
- `in_ready` deasserts in the cycle after the `DEPTH`th unpopped accept. It reasserts the cycle after a pop from FULL.
- Sustained throughput: one beat per cycle when `out_ready` is held high.

## Structure
- `result_pkg`:
  - `typedef struct packed { logic [16:0] data_C; logic is_eq; } result_t` (18 bits).
  - Constant `RES_W = 18`.
  - Default `ACC_W`/`CNT_W` localparams.
- One sub-module, `result_fifo`: a `result_t`-wide, `DEPTH`-entry synchronous FIFO with count, full and empty.
- Statistics logic lives in `result_collector`.

## Test plan
- Reset, then three beats (0,eq=1), (3,eq=0), (24,eq=1) with `out_ready`=1:
  - outputs appear in order, one cycle after each accept;
  - `acc_sum`=27, `eq_count`=2, `total_count`=3.
- Hold `out_ready`=0 and push 5 beats:
  - `in_ready` drops after the 4th accept; the 5th beat is held;
  - after one pop it is accepted, and the FIFO order is preserved across pointer wrap.
- FIFO at count 2, push and pop in the same cycle: count stays 2; the head advances to the next entry.
- `ACC_W`=17, accept 0x1FFFF then 1: `acc_sum`=0x1FFFF and `acc_ovf`=1, and both stay so after further accepts until `clear`.
- `clear` together with accept of (12, eq=1): next cycle `acc_sum`=12, `eq_count`=1, `total_count`=1.
- Assert `rst_n` low with 3 buffered beats: `out_valid`=0 and stats are 0 immediately; the first post-reset beat is the first output.
